// File: rtl/common.sv
// Shared types and constants for the resource arbiter slice.
package common;

  // FSM state type shared by sequencing blocks.
  typedef enum logic [2:0] {
    S0 = 3'd0,  // IDLE
    S1 = 3'd1,  // ARB
    S2 = 3'd2,  // GRANT
    S3 = 3'd3,  // BUSY
    S4 = 3'd4   // RELEASE
  } example_states;

  localparam int unsigned DEFAULT_MAX_HOLD = 16;

endpackage : common

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set request after last_id, modulo N_REQ.
module rr_pick #(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req_i,
  input  logic [$clog2(N_REQ)-1:0] last_id_i,
  output logic [$clog2(N_REQ)-1:0] winner_c_o,
  output logic                     valid_c_o
);

  localparam int unsigned IDW = $clog2(N_REQ);

  // Scan from farthest to nearest so the nearest set bit after last_id wins.
  always_comb begin
    winner_c_o = '0;
    valid_c_o  = 1'b0;
    for (int i = int'(N_REQ); i >= 1; i--) begin
      logic [IDW-1:0] idx;
      idx = IDW'((int'(last_id_i) + i) % int'(N_REQ));
      if (req_i[idx]) begin
        winner_c_o = idx;
        valid_c_o  = 1'b1;
      end
    end
  end

endmodule : rr_pick

// File: rtl/rr_resource_arbiter.sv
// Round-robin owner controller for a single shared downstream resource.
module rr_resource_arbiter
  import common::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned MAX_HOLD = DEFAULT_MAX_HOLD
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic                     done,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] gnt_id,
  output logic                     start,
  output logic                     busy,
  output logic                     timeout
);

  localparam int unsigned IDW = $clog2(N_REQ);
  localparam int unsigned HCW = $clog2(MAX_HOLD);

  example_states    state_q, state_d;
  logic [IDW-1:0]   owner_q, owner_d;
  logic [IDW-1:0]   last_id_q, last_id_d;
  logic [HCW-1:0]   hold_q, hold_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;
  logic             timeout_q, timeout_d;

  logic [IDW-1:0]   pick_id_c;
  logic             pick_valid_c;
  logic             at_limit_c;
  logic             release_c;

  rr_pick #(
    .N_REQ(N_REQ)
  ) u_pick (
    .req_i      (req),
    .last_id_i  (last_id_q),
    .winner_c_o (pick_id_c),
    .valid_c_o  (pick_valid_c)
  );

  // Ownership end conditions evaluated while in BUSY.
  always_comb begin
    at_limit_c = (hold_q == HCW'(MAX_HOLD - 1));
    release_c  = done || !req[owner_q] || at_limit_c;
  end

  // Next-state logic; outputs are derived from the next state so they register with it.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_id_d = last_id_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;

    case (state_q)
      S0: begin
        if (|req) state_d = S1;
      end
      S1: begin
        if (pick_valid_c) begin
          owner_d = pick_id_c;
          state_d = S2;
        end else begin
          state_d = S0;
        end
      end
      S2: begin
        hold_d  = '0;
        state_d = S3;
      end
      S3: begin
        if (release_c) begin
          state_d   = S4;
          timeout_d = at_limit_c && !done;
        end else begin
          hold_d = hold_q + HCW'(1);
        end
      end
      S4: begin
        last_id_d = owner_q;
        state_d   = (|req) ? S1 : S0;
      end
      default: state_d = S0;
    endcase

    busy_d  = (state_d == S2) || (state_d == S3);
    start_d = (state_d == S2);
    gnt_d   = busy_d ? (N_REQ'(1) << owner_d) : '0;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S0;
      owner_q   <= '0;
      last_id_q <= IDW'(N_REQ - 1);
      hold_q    <= '0;
      gnt_q     <= '0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_id_q <= last_id_d;
      hold_q    <= hold_d;
      gnt_q     <= gnt_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = owner_q;
  assign start   = start_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule : rr_resource_arbiter

// File: tb/tb_rr_resource_arbiter.sv
// Directed vector bench for rr_resource_arbiter (N_REQ=4, MAX_HOLD=16).
module tb_rr_resource_arbiter;

  localparam int unsigned N_REQ    = 4;
  localparam int unsigned MAX_HOLD = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       start;
  logic       busy;
  logic       timeout;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  rr_resource_arbiter #(
    .N_REQ    (N_REQ),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .start   (start),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  // One row = inputs held for one cycle, expected outputs after the following edge.
  typedef struct {
    string      name;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       start;
    logic       busy;
    logic       to;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input string name, input logic r, input logic [3:0] rq,
                              input logic d, input logic [3:0] g, input logic [1:0] id,
                              input logic s, input logic b, input logic t);
    vec_t v;
    v.name = name; v.rst_n = r; v.req = rq; v.done = d;
    v.gnt = g; v.id = id; v.start = s; v.busy = b; v.to = t;
    vecs.push_back(v);
  endfunction

  task automatic step(input string name, input logic r, input logic [3:0] rq,
                      input logic d, input logic [3:0] g, input logic [1:0] id,
                      input logic s, input logic b, input logic t);
    logic [8:0] got, exp;
    rst_n = r;
    req   = rq;
    done  = d;
    @(posedge clk);
    #1;
    cyc++;
    got = {gnt, gnt_id, start, busy, timeout};
    exp = {g, id, s, b, t};
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc %0d: got gnt=%b id=%0d start=%b busy=%b timeout=%b, required gnt=%b id=%0d start=%b busy=%b timeout=%b",
               name, cyc, gnt, gnt_id, start, busy, timeout, g, id, s, b, t);
    end
  endtask

  initial begin
    logic [3:0] oh;
    logic [1:0] k_id;

    rst_n = 1'b0;
    req   = '0;
    done  = 1'b0;

    // Reset state.
    add("reset0", 0, 4'b0000, 0, 4'b0000, 2'd0, 0, 0, 0);
    add("reset1", 0, 4'b0000, 0, 4'b0000, 2'd0, 0, 0, 0);

    // Single requester 2 from idle, done on the third BUSY cycle.
    add("single_s1",   1, 4'b0100, 0, 4'b0000, 2'd0, 0, 0, 0);
    add("single_s2",   1, 4'b0100, 0, 4'b0100, 2'd2, 1, 1, 0);
    add("single_s3a",  1, 4'b0100, 0, 4'b0100, 2'd2, 0, 1, 0);
    add("single_s3b",  1, 4'b0100, 0, 4'b0100, 2'd2, 0, 1, 0);
    add("single_s3c",  1, 4'b0100, 0, 4'b0100, 2'd2, 0, 1, 0);
    add("single_s4",   1, 4'b0100, 1, 4'b0000, 2'd2, 0, 0, 0);
    add("single_s0",   1, 4'b0000, 0, 4'b0000, 2'd2, 0, 0, 0);
    add("single_idle", 1, 4'b0000, 1, 4'b0000, 2'd2, 0, 0, 0);

    // Reset restores req[0] as top priority.
    add("rst_again", 0, 4'b0000, 0, 4'b0000, 2'd0, 0, 0, 0);

    // Round robin over all four, done two cycles after each start.
    add("rr_s1", 1, 4'b1111, 0, 4'b0000, 2'd0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      oh   = 4'b0001 << (k % 4);
      k_id = 2'(k % 4);
      add("rr_start", 1, 4'b1111, 0, oh,      k_id, 1, 1, 0);
      add("rr_busy0", 1, 4'b1111, 0, oh,      k_id, 0, 1, 0);
      add("rr_busy1", 1, 4'b1111, 0, oh,      k_id, 0, 1, 0);
      add("rr_rel",   1, 4'b1111, 1, 4'b0000, k_id, 0, 0, 0);
      if (k < 4) add("rr_arb", 1, 4'b1111, 0, 4'b0000, k_id, 0, 0, 0);
    end
    add("rr_idle", 1, 4'b0000, 0, 4'b0000, 2'd0, 0, 0, 0);

    // Owner 3 withdraws in BUSY; pending requester 0 follows two cycles later.
    add("wd_s1",    1, 4'b1001, 0, 4'b0000, 2'd0, 0, 0, 0);
    add("wd_s2",    1, 4'b1001, 0, 4'b1000, 2'd3, 1, 1, 0);
    add("wd_s3",    1, 4'b1001, 0, 4'b1000, 2'd3, 0, 1, 0);
    add("wd_rel",   1, 4'b0001, 0, 4'b0000, 2'd3, 0, 0, 0);
    add("wd_arb",   1, 4'b0001, 0, 4'b0000, 2'd3, 0, 0, 0);
    add("wd_g0",    1, 4'b0001, 0, 4'b0001, 2'd0, 1, 1, 0);
    add("wd_g0b",   1, 4'b0001, 0, 4'b0001, 2'd0, 0, 1, 0);
    add("wd_g0rel", 1, 4'b0001, 1, 4'b0000, 2'd0, 0, 0, 0);
    add("wd_idle",  1, 4'b0000, 0, 4'b0000, 2'd0, 0, 0, 0);
    // Request withdrawn while arbitrating.
    add("arbwd_s1", 1, 4'b0100, 0, 4'b0000, 2'd0, 0, 0, 0);
    add("arbwd_s0", 1, 4'b0000, 0, 4'b0000, 2'd0, 0, 0, 0);
    add("arbwd_id", 1, 4'b0000, 0, 4'b0000, 2'd0, 0, 0, 0);

    foreach (vecs[i])
      step(vecs[i].name, vecs[i].rst_n, vecs[i].req, vecs[i].done,
           vecs[i].gnt, vecs[i].id, vecs[i].start, vecs[i].busy, vecs[i].to);

    // Timeout: sole requester 1 never signals done; grant lasts MAX_HOLD+1 cycles.
    step("to_s1", 1, 4'b0010, 0, 4'b0000, 2'd0, 0, 0, 0);
    step("to_s2", 1, 4'b0010, 0, 4'b0010, 2'd1, 1, 1, 0);
    for (int h = 0; h < int'(MAX_HOLD); h++)
      step("to_hold", 1, 4'b0010, 0, 4'b0010, 2'd1, 0, 1, 0);
    step("to_pulse", 1, 4'b0010, 0, 4'b0000, 2'd1, 0, 0, 1);
    step("to_arb",   1, 4'b0010, 0, 4'b0000, 2'd1, 0, 0, 0);
    step("to_regnt", 1, 4'b0010, 0, 4'b0010, 2'd1, 1, 1, 0);

    // Coincidence: done on the limit cycle releases without timeout.
    for (int h = 0; h < int'(MAX_HOLD); h++)
      step("co_hold", 1, 4'b0010, 0, 4'b0010, 2'd1, 0, 1, 0);
    step("co_rel",  1, 4'b0010, 1, 4'b0000, 2'd1, 0, 0, 0);
    step("co_idle", 1, 4'b0000, 0, 4'b0000, 2'd1, 0, 0, 0);

    // Reset while owner 2 is in BUSY, then priority restarts at requester 0.
    step("mr_s1",    1, 4'b0100, 0, 4'b0000, 2'd1, 0, 0, 0);
    step("mr_s2",    1, 4'b0100, 0, 4'b0100, 2'd2, 1, 1, 0);
    step("mr_s3",    1, 4'b0100, 0, 4'b0100, 2'd2, 0, 1, 0);
    step("mr_rst",   0, 4'b0100, 0, 4'b0000, 2'd0, 0, 0, 0);
    step("mr_s1b",   1, 4'b1001, 0, 4'b0000, 2'd0, 0, 0, 0);
    step("mr_g0",    1, 4'b1001, 0, 4'b0001, 2'd0, 1, 1, 0);
    step("mr_busy",  1, 4'b1001, 0, 4'b0001, 2'd0, 0, 1, 0);
    step("mr_rel",   1, 4'b1001, 1, 4'b0000, 2'd0, 0, 0, 0);
    step("mr_arb",   1, 4'b1000, 0, 4'b0000, 2'd0, 0, 0, 0);
    step("mr_g3",    1, 4'b1000, 0, 4'b1000, 2'd3, 1, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_rr_resource_arbiter

// File: doc/rr_resource_arbiter.md
Name: rr_resource_arbiter

Overview:
- Round-robin arbiter/controller that shares one downstream resource (e.g. a single-port datapath or bus) between N_REQ requesters.
- Sequenced by a 5-state FSM whose state type is the shared `common::example_states` enum (S0..S4).
- Issues a one-hot grant and a start pulse to the resource, holds ownership until release, done or timeout, then rotates priority.
- Sits between the requester blocks and the shared resource.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- MAX_HOLD, 16, maximum number of cycles an owner may hold the grant in S3 before forced release (>=2).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; one clock; reset is synchronous and active-low.
- req  in  N_REQ  per-requester request level; held high while the requester wants or owns the resource.
- done  in  1  resource completion pulse; ends the current ownership.
- gnt  out  N_REQ  one-hot grant; all zero when nobody owns the resource.
- gnt_id  out  $clog2(N_REQ)  index of the current or last owner.
- start  out  1  one-cycle pulse to the resource at the start of an ownership.
- busy  out  1  high while the state is S2 or S3.
- timeout  out  1  one-cycle pulse when an ownership is force-released by the hold limit.

Behaviour:
- All outputs are registered or decoded from registered state; no combinational path from req or done to outputs.
- Reset (rst_n=0 at a clk edge):
  - state=S0; gnt=0, start=0, busy=0, timeout=0, gnt_id=0.
  - last_id=N_REQ-1, so req[0] has top priority first.
  - hold_cnt=0.
  - Reset mid-ownership drops gnt at that same edge; no start, done or timeout side effects.
- S0 IDLE: no grant. If any req bit=1 -> S1, else stay.
- S1 ARB:
  - Winner = first set req bit searching last_id+1, last_id+2, ... modulo N_REQ.
  - Winner is registered into owner/gnt_id -> S2.
  - If req==0 (requests withdrawn) -> S0, no grant.
- S2 GRANT:
  - gnt=onehot(owner), start=1 for exactly this cycle, busy=1.
  - hold_cnt cleared -> S3 unconditionally.
- S3 BUSY:
  - gnt held, busy=1, hold_cnt increments each cycle.
  - Exit to S4 on the first cycle where any of these holds: done=1; req[owner]=0; hold_cnt==MAX_HOLD-1.
  - If done=1 and the limit coincide, done wins: timeout stays 0.
  - req of non-owners is ignored (no preemption).
- S4 RELEASE:
  - gnt=0, busy=0; last_id<=owner.
  - timeout=1 for this cycle only if the exit was by limit.
  - Then -> S1 if any req=1, else S0.
- Latency:
  - req sampled at edge k in S0 -> S1 at k; S2 at k+1; gnt/start visible after edge k+1.
  - Back-to-back ownerships are separated by exactly 2 grant-free cycles (S4, S1).
- Maximum grant length is MAX_HOLD+1 cycles (S2 + MAX_HOLD in S3).
- gnt is always one-hot or zero; gnt_id retains the last owner in S0/S1/S4.
- hold_cnt width is $clog2(MAX_HOLD); it never wraps because exit occurs at MAX_HOLD-1.
- done outside S3 is ignored.

Decomposition:
- common package: reuse `example_states` (S0 IDLE, S1 ARB, S2 GRANT, S3 BUSY, S4 RELEASE) as the FSM state type.
- common package: add localparam DEFAULT_MAX_HOLD=16.
- Sub-module `rr_pick`: combinational rotate-priority picker.
  - Inputs: req and last_id.
  - Outputs: winner index and valid.
  - Parameterised by N_REQ.
- The FSM, counters and output registers live in the top.

Test Plan:
- Single requester:
  - req=4'b0100 at cycle 0 from idle -> gnt=4'b0100, gnt_id=2, start pulse at cycle 2.
  - done at cycle 5 -> gnt=0 at cycle 6, back in S0 at cycle 7.
- Round-robin:
  - req=4'b1111 held, done 2 cycles after each start -> grant order 0,1,2,3,0.
  - 2 idle-grant cycles between ownerships.
- Timeout:
  - req=4'b0010 held, done never asserted, MAX_HOLD=16 -> gnt high 17 cycles.
  - Then timeout=1 for one cycle and gnt=0.
  - Re-grant to 1 follows (sole requester).
- Coincidence:
  - done=1 exactly on the cycle hold_cnt==15 -> release with timeout=0.
- Withdrawal:
  - Owner 3 drops req[3] in S3 without done -> release next cycle.
  - Pending req[0] is granted 2 cycles later.
  - req withdrawn during S1 -> return to S0, gnt never asserted.
- Reset mid-operation:
  - rst_n=0 while owner 2 is in S3 -> gnt=0, busy=0 after that edge.
  - After release of reset with req=4'b1001 -> req[0] is granted first.
